// File: rtl/fast_stopbit_splitter.sv
// FAST stop-bit field splitter: turns 64-bit raw byte beats into 7-bit-per-byte
// concatenated field values, up to sup_paths per cycle, tagging PMAP/TID fields.
module fast_stopbit_splitter #(
    parameter int unsigned beat_width      = 64,
    parameter int unsigned sup_paths       = 4,
    parameter int unsigned max_field_bytes = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [beat_width-1:0]                 s_data,
    input  logic [3:0]                            s_bytes,
    input  logic                                  s_last,
    output logic [sup_paths*(beat_width+2)-1:0]   dins,
    output logic [sup_paths:0]                    field_valids,
    output logic [sup_paths-1:0]                  field_ovf,
    output logic                                  new_message,
    output logic                                  err_trunc
);

    localparam int unsigned NB   = beat_width / 8;
    localparam int unsigned CURW = $clog2(NB);
    localparam int unsigned CW   = $clog2(max_field_bytes + 2);
    localparam int unsigned SW   = beat_width + 2;
    localparam logic [CW-1:0] CNT_MAX = CW'(max_field_bytes);
    localparam logic [CW-1:0] CNT_SAT = CW'(max_field_bytes + 1);

    typedef enum logic [1:0] {
        IDX_PMAP = 2'd0,
        IDX_TID  = 2'd1,
        IDX_BODY = 2'd2
    } fidx_e;

    // Beat buffer
    logic                  buf_valid_q;
    logic [beat_width-1:0] buf_data_q;
    logic [3:0]            buf_bytes_q;
    logic                  buf_last_q;
    logic [CURW-1:0]       cur_q, cur_d;

    // Field assembly state, persistent across beats
    logic [beat_width-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    fidx_e                 idx_q, idx_d;

    // Per-cycle scan results
    logic [beat_width-1:0] slot_val [sup_paths];
    logic [sup_paths-1:0]  slot_vld;
    logic [sup_paths-1:0]  slot_ovf;
    logic [sup_paths-1:0]  slot_pmap;
    logic [sup_paths-1:0]  slot_tid;
    logic                  consumed;
    logic                  msg_end;
    logic                  trunc;

    // Registered outputs
    logic [sup_paths*SW-1:0] dins_q, dins_d;
    logic [sup_paths:0]      fv_q, fv_d;
    logic [sup_paths-1:0]    ovf_q, ovf_d;
    logic                    nm_q, nm_d;
    logic                    trunc_q;

    // Byte walk: each byte is a sequential step so multiple fields can
    // complete in one cycle; the scan stops once every slot is used.
    always_comb begin
        int unsigned nd;
        int unsigned nxt;
        logic        stop;
        logic [7:0]  b;

        nd       = 0;
        nxt      = 0;
        stop     = 1'b0;
        b        = '0;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        cur_d    = cur_q;
        slot_vld  = '0;
        slot_ovf  = '0;
        slot_pmap = '0;
        slot_tid  = '0;
        for (int unsigned k = 0; k < sup_paths; k++) begin
            slot_val[k] = '0;
        end

        for (int unsigned i = 0; i < NB; i++) begin
            if (buf_valid_q && !stop && i >= 32'(cur_q) && i < 32'(buf_bytes_q)) begin
                b     = buf_data_q[beat_width-1-8*i -: 8];
                acc_d = {acc_d[beat_width-8:0], b[6:0]};
                if (cnt_d != CNT_SAT) begin
                    cnt_d = cnt_d + 1'b1;
                end
                if (b[7]) begin
                    for (int unsigned k = 0; k < sup_paths; k++) begin
                        if (k == nd) begin
                            slot_vld[k]  = 1'b1;
                            slot_val[k]  = acc_d;
                            slot_ovf[k]  = (cnt_d > CNT_MAX);
                            slot_pmap[k] = (idx_d == IDX_PMAP);
                            slot_tid[k]  = (idx_d == IDX_TID);
                        end
                    end
                    case (idx_d)
                        IDX_PMAP: idx_d = IDX_TID;
                        default:  idx_d = IDX_BODY;
                    endcase
                    acc_d = '0;
                    cnt_d = '0;
                    nd    = nd + 1;
                    if (nd == sup_paths) begin
                        stop = 1'b1;
                        nxt  = i + 1;
                    end
                end
            end
        end

        consumed = buf_valid_q && !(stop && nxt < 32'(buf_bytes_q));
        if (buf_valid_q && !consumed) begin
            cur_d = CURW'(nxt);
        end

        msg_end = consumed && buf_last_q;
        trunc   = msg_end && (cnt_d != '0);
        if (msg_end) begin
            acc_d = '0;
            cnt_d = '0;
            idx_d = IDX_PMAP;
        end
    end

    always_comb begin
        dins_d = '0;
        for (int unsigned k = 0; k < sup_paths; k++) begin
            dins_d[k*SW +: SW] = {slot_pmap[k], slot_tid[k], slot_val[k]};
        end
        fv_d  = {msg_end, slot_vld};
        ovf_d = slot_ovf;
        nm_d  = |slot_tid;
    end

    assign s_ready = !rst && (!buf_valid_q || consumed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            buf_bytes_q <= '0;
            buf_last_q  <= 1'b0;
            cur_q       <= '0;
        end else if (s_valid && s_ready) begin
            buf_valid_q <= 1'b1;
            buf_data_q  <= s_data;
            buf_bytes_q <= s_bytes;
            buf_last_q  <= s_last;
            cur_q       <= '0;
        end else if (consumed) begin
            buf_valid_q <= 1'b0;
            cur_q       <= '0;
        end else begin
            cur_q       <= cur_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= IDX_PMAP;
            dins_q  <= '0;
            fv_q    <= '0;
            ovf_q   <= '0;
            nm_q    <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dins_q  <= dins_d;
            fv_q    <= fv_d;
            ovf_q   <= ovf_d;
            nm_q    <= nm_d;
            trunc_q <= trunc;
        end
    end

    assign dins         = dins_q;
    assign field_valids = fv_q;
    assign field_ovf    = ovf_q;
    assign new_message  = nm_q;
    assign err_trunc    = trunc_q;

endmodule
